muldiv_sequencer: RTL and testbench

// - Iterative RV32M multiply/divide unit with its own FSM and iteration counter.
// - Sits beside the main ALU in EX. Decode raises start for OP-type funct7=0000001 instructions.
// - Holds the pipeline through stall until the result is ready.
// - Runs all 8 M ops (funct3 selects) with one shared shift/add/subtract datapath.

---
 rtl/muldiv_pkg.sv | 59 +++++
 rtl/muldiv_step.sv | 61 ++++++
 rtl/muldiv_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// ----------------------------------------------------------------------------
// muldiv_pkg
// Shared types and constants for the iterative RV32M multiply/divide unit.
//   muldiv_state_t : sequencer FSM states
//   F3_*           : funct3 encodings of the eight M-extension operations
//   FUNCT7_MULDIV  : funct7 value that marks an OP-type instruction as M-type
//   f3_* helpers   : per-operation decode (divide/remainder, operand signedness)
// ----------------------------------------------------------------------------
package muldiv_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      CALC = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } muldiv_state_t;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   // All divide/remainder operations share funct3[2] = 1
   function automatic logic f3_is_div(input logic [2:0] f3);
      return f3[2];
   endfunction

   function automatic logic f3_is_rem(input logic [2:0] f3);
      return (f3 == F3_REM) || (f3 == F3_REMU);
   endfunction

   // rs1 is treated as signed for MUL/MULH/MULHSU/DIV/REM
   function automatic logic f3_a_signed(input logic [2:0] f3);
      logic res;
      case (f3)
         F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM: res = 1'b1;
         default:                                    res = 1'b0;
      endcase
      return res;
   endfunction

   // rs2 is treated as signed only for MUL/MULH/DIV/REM (MULHSU takes it unsigned)
   function automatic logic f3_b_signed(input logic [2:0] f3);
      logic res;
      case (f3)
         F3_MUL, F3_MULH, F3_DIV, F3_REM: res = 1'b1;
         default:                         res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// ----------------------------------------------------------------------------
// muldiv_step
// One combinational radix-2 iteration on the {acc, q} register pair.
//   is_div_i = 0 : shift-add multiply. q holds the remaining multiplier bits,
//                  opnd is the multiplicand; {acc, q} shifts right by one and
//                  ends up holding the full 2*WIDTH product.
//   is_div_i = 1 : restoring divide. q holds the remaining dividend bits and
//                  collects quotient bits, acc is the partial remainder,
//                  opnd is the divisor; {acc, q} shifts left by one.
// Ports:
//   is_div_i  in   1      select divide step (1) or multiply step (0)
//   acc_i     in   WIDTH  current accumulator / partial remainder
//   q_i       in   WIDTH  current multiplier / dividend-quotient word
//   opnd_i    in   WIDTH  multiplicand or divisor magnitude
//   acc_o     out  WIDTH  accumulator after this step
//   q_o       out  WIDTH  q word after this step
// ----------------------------------------------------------------------------
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div_i,
   input  logic [WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] opnd_i,
   output logic [WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH:0] sum_s;
   logic [WIDTH:0] trial_s;
   logic [WIDTH:0] diff_s;

   // Single shift-add or trial-subtract iteration
   always_comb begin
      // Carry out of the add is kept so the right shift does not lose it
      sum_s   = {1'b0, acc_i} + {1'b0, opnd_i};
      // Partial remainder shifted left with the next dividend bit brought in
      trial_s = {acc_i, q_i[WIDTH-1]};
      // Bit WIDTH of the difference is set exactly when trial < divisor
      diff_s  = trial_s - {1'b0, opnd_i};

      if (is_div_i) begin
         if (!diff_s[WIDTH]) begin
            acc_o = diff_s[WIDTH-1:0];
            q_o   = {q_i[WIDTH-2:0], 1'b1};
         end else begin
            acc_o = trial_s[WIDTH-1:0];
            q_o   = {q_i[WIDTH-2:0], 1'b0};
         end
      end else begin
         if (q_i[0]) begin
            acc_o = sum_s[WIDTH:1];
            q_o   = {sum_s[0], q_i[WIDTH-1:1]};
         end else begin
            acc_o = {1'b0, acc_i[WIDTH-1:1]};
            q_o   = {acc_i[0], q_i[WIDTH-1:1]};
         end
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// ----------------------------------------------------------------------------
// muldiv_sequencer
// Iterative RV32M multiply/divide unit sitting beside the EX-stage ALU.
// Operands are latched on an accepted start, converted to magnitudes, run
// through WIDTH shift-add / restoring-divide iterations and sign-fixed.
// Divide-by-zero and signed overflow short-circuit straight to DONE.
// Ports:
//   clk     in   1      system clock
//   reset   in   1      synchronous active-high reset
//   start   in   1      M-instruction present in EX (level, held while stalled)
//   kill    in   1      EX flush; aborts any in-flight operation
//   funct3  in   3      operation select (MUL..REMU)
//   op_a    in   WIDTH  rs1 (multiplicand / dividend)
//   op_b    in   WIDTH  rs2 (multiplier / divisor)
//   stall   out  1      freeze IF/ID/EX (combinational)
//   done    out  1      one-cycle result-valid pulse
//   result  out  WIDTH  registered result, held until the next completion
// ----------------------------------------------------------------------------
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             kill,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   import muldiv_pkg::*;

   localparam int              CW       = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

   // Architectural state
   muldiv_state_t    state_q;
   logic [CW-1:0]    cnt_q;
   logic [2:0]       f3_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] opnd_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] qr_q;
   logic             neg_q;    // product / quotient must be negated
   logic             rneg_q;   // remainder must be negated (dividend was negative)
   logic [WIDTH-1:0] result_q;
   logic             done_q;

   // Next values produced by the iteration datapath
   logic [WIDTH-1:0] acc_d;
   logic [WIDTH-1:0] qr_d;

   // Operand preparation and special-case decode
   logic             a_neg_s;
   logic             b_neg_s;
   logic [WIDTH-1:0] mag_a_s;
   logic [WIDTH-1:0] mag_b_s;
   logic             div_zero_s;
   logic             div_ovf_s;
   logic             special_s;
   logic [WIDTH-1:0] spec_res_s;

   // Sign fix and result selection
   logic [2*WIDTH-1:0] prod_raw_s;
   logic [2*WIDTH-1:0] prod_fix_s;
   logic [WIDTH-1:0]   quot_s;
   logic [WIDTH-1:0]   rem_s;
   logic [WIDTH-1:0]   fix_res_s;

   muldiv_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .is_div_i (f3_is_div(f3_q)),
      .acc_i    (acc_q),
      .q_i      (qr_q),
      .opnd_i   (opnd_q),
      .acc_o    (acc_d),
      .q_o      (qr_d)
   );

   // Magnitudes of the latched operands and detection of the short-circuit divides
   always_comb begin
      a_neg_s = f3_a_signed(f3_q) & a_q[WIDTH-1];
      b_neg_s = f3_b_signed(f3_q) & b_q[WIDTH-1];

      // -INT_MIN wraps back to INT_MIN, which is the correct unsigned magnitude
      if (a_neg_s) begin
         mag_a_s = -a_q;
      end else begin
         mag_a_s = a_q;
      end
      if (b_neg_s) begin
         mag_b_s = -b_q;
      end else begin
         mag_b_s = b_q;
      end

      div_zero_s = (b_q == ZERO);
      div_ovf_s  = f3_b_signed(f3_q) & (a_q == INT_MIN) & (b_q == ALL_ONES);
      special_s  = f3_is_div(f3_q) & (div_zero_s | div_ovf_s);

      if (div_zero_s) begin
         if (f3_is_rem(f3_q)) begin
            spec_res_s = a_q;
         end else begin
            spec_res_s = ALL_ONES;
         end
      end else begin
         if (f3_is_rem(f3_q)) begin
            spec_res_s = ZERO;
         end else begin
            spec_res_s = a_q;
         end
      end
   end

   // Sign correction of the raw magnitude results and final word selection
   always_comb begin
      prod_raw_s = {acc_q, qr_q};
      if (neg_q) begin
         prod_fix_s = -prod_raw_s;
         quot_s     = -qr_q;
      end else begin
         prod_fix_s = prod_raw_s;
         quot_s     = qr_q;
      end
      if (rneg_q) begin
         rem_s = -acc_q;
      end else begin
         rem_s = acc_q;
      end

      case (f3_q)
         F3_MUL:                       fix_res_s = prod_fix_s[WIDTH-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: fix_res_s = prod_fix_s[2*WIDTH-1:WIDTH];
         F3_DIV, F3_DIVU:              fix_res_s = quot_s;
         F3_REM, F3_REMU:              fix_res_s = rem_s;
         default:                      fix_res_s = prod_fix_s[WIDTH-1:0];
      endcase
   end

   // Sequencer FSM, iteration counter, operand latches and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= {CW{1'b0}};
         f3_q     <= 3'b000;
         a_q      <= ZERO;
         b_q      <= ZERO;
         opnd_q   <= ZERO;
         acc_q    <= ZERO;
         qr_q     <= ZERO;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         result_q <= ZERO;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start && !kill) begin
                  f3_q    <= funct3;
                  a_q     <= op_a;
                  b_q     <= op_b;
                  state_q <= PREP;
               end else begin
                  state_q <= IDLE;
               end
            end

            PREP: begin
               if (kill) begin
                  state_q <= IDLE;
               end else begin
                  cnt_q  <= CW'(WIDTH - 1);
                  acc_q  <= ZERO;
                  neg_q  <= a_neg_s ^ b_neg_s;
                  rneg_q <= a_neg_s;
                  // Divide streams the dividend through q; multiply streams the multiplier
                  if (f3_is_div(f3_q)) begin
                     qr_q   <= mag_a_s;
                     opnd_q <= mag_b_s;
                  end else begin
                     qr_q   <= mag_b_s;
                     opnd_q <= mag_a_s;
                  end
                  if (special_s) begin
                     result_q <= spec_res_s;
                     done_q   <= 1'b1;
                     state_q  <= DONE;
                  end else begin
                     state_q  <= CALC;
                  end
               end
            end

            CALC: begin
               if (kill) begin
                  state_q <= IDLE;
               end else begin
                  acc_q <= acc_d;
                  qr_q  <= qr_d;
                  cnt_q <= cnt_q - CW'(1);
                  if (cnt_q == {CW{1'b0}}) begin
                     state_q <= FIX;
                  end else begin
                     state_q <= CALC;
                  end
               end
            end

            FIX: begin
               if (kill) begin
                  state_q <= IDLE;
               end else begin
                  result_q <= fix_res_s;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end
            end

            DONE: begin
               // start is deliberately ignored here; a new accept happens from IDLE
               state_q <= IDLE;
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign stall  = ((state_q == IDLE) && start && !kill) ||
                   (state_q == PREP) || (state_q == CALC) || (state_q == FIX);
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Directed and randomized checks of muldiv_sequencer against an arithmetic
// reference model of the RV32M operations.
// ----------------------------------------------------------------------------
module tb_muldiv_sequencer;

   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        kill;
   logic [2:0]  funct3;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        stall;
   logic        done;
   logic [31:0] result;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int last_done_cyc = 0;
   logic [31:0] last_res = 32'h0;

   muldiv_sequencer #(.WIDTH(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .kill   (kill),
      .funct3 (funct3),
      .op_a   (op_a),
      .op_b   (op_b),
      .stall  (stall),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   // Cycle counter used for spacing between completions
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: RV32M semantics from plain 64-bit arithmetic
   function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
      longint      sa, sb, ub;
      logic [63:0] p;
      logic [31:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'h0, b});
      case (f)
         3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
         3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
         3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
         3'd3: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
         3'd4: r = (b == 32'h0) ? 32'hFFFF_FFFF : 32'(sa / sb);
         3'd5: r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
         3'd6: r = (b == 32'h0) ? a : 32'(sa % sb);
         default: r = (b == 32'h0) ? a : a % b;
      endcase
      return r;
   endfunction

   function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      bit special;
      special = f[2] && ((b == 32'h0) ||
                ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      return special ? 2 : 35;
   endfunction

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(5, 0))
         0: v = 32'h0;
         1: v = 32'h1;
         2: v = 32'hFFFF_FFFF;
         3: v = 32'h8000_0000;
         4: v = 32'($urandom_range(15, 0));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Issue one operation starting at the current negedge (cycle 0) and follow it to done
   task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat,
                        input bit hold, input bit toggle);
      int n;
      bit seen;
      bit stall_ok;
      funct3 = f; op_a = a; op_b = b; start = 1'b1; kill = 1'b0;
      #1;
      stall_ok = (stall === 1'b1);
      n = 0;
      seen = 0;
      while (!seen && n < 100) begin
         @(negedge clk);
         n++;
         if (done === 1'b1) begin
            seen = 1;
         end else begin
            if (stall !== 1'b1) stall_ok = 0;
            if (toggle && n >= 2 && n <= 33) begin
               start  = 1'($urandom);
               op_a   = $urandom;
               op_b   = $urandom;
               funct3 = 3'($urandom);
            end
         end
      end
      last_done_cyc = cyc;
      chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
      chk({tag, "_result"}, result, exp_r);
      chk({tag, "_stall_busy"}, 32'(stall_ok), 32'd1);
      chk({tag, "_stall_done"}, 32'(stall), 32'd0);
      last_res = exp_r;
      if (!hold) begin
         start = 1'b0;
         @(negedge clk);
         chk({tag, "_done_pulse"}, 32'(done), 32'd0);
         chk({tag, "_result_hold"}, result, exp_r);
      end
   endtask

   initial begin
      logic [2:0]  f;
      logic [31:0] a, b;
      bit          kseen;
      int          d1;

      reset = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 3'b000;
      op_a = 32'h0; op_b = 32'h0;
      repeat (3) @(negedge clk);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_result", result, 32'h0);
      chk("reset_stall", 32'(stall), 32'd0);
      start = 1'b1; #1;
      chk("reset_stall_start", 32'(stall), 32'd1);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      // kill together with start in IDLE must not accept
      start = 1'b1; kill = 1'b1; #1;
      chk("idle_kill_stall", 32'(stall), 32'd0);
      @(negedge clk);
      start = 1'b0; kill = 1'b0; #1;
      chk("idle_kill_noaccept", 32'(stall), 32'd0);
      @(negedge clk);

      do_op("mul",     F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 35, 0, 0);
      do_op("mulh",    F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 35, 0, 0);
      do_op("mulhu",   F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 35, 0, 0);
      do_op("mulhsu",  F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 35, 0, 0);
      do_op("div",     F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 35, 0, 0);
      do_op("rem",     F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 35, 0, 0);
      do_op("divu",    F3_DIVU,   32'd100,        32'd7,         32'd14,        35, 0, 0);
      do_op("remu",    F3_REMU,   32'd100,        32'd7,         32'd2,         35, 0, 0);
      do_op("divu_z",  F3_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 2,  0, 0);
      do_op("remu_z",  F3_REMU,   32'd5,          32'd0,         32'd5,         2,  0, 0);
      do_op("div_ovf", F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2,  0, 0);
      do_op("rem_ovf", F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         2,  0, 0);

      // kill in cycle 10 of a divide
      funct3 = F3_DIV; op_a = 32'd1000; op_b = 32'd3; start = 1'b1; kill = 1'b0;
      kseen = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (done === 1'b1) kseen = 1;
      end
      kill = 1'b1; start = 1'b0; #1;
      chk("kill_stall_busy", 32'(stall), 32'd1);
      @(negedge clk);
      kill = 1'b0; #1;
      if (done === 1'b1) kseen = 1;
      chk("kill_idle", 32'(stall), 32'd0);
      chk("kill_no_done", 32'(kseen), 32'd0);
      chk("kill_result", result, last_res);
      do_op("after_kill", F3_REMU, 32'd100, 32'd7, 32'd2, 35, 0, 0);

      // reset in cycle 20 of a multiply
      funct3 = F3_MUL; op_a = 32'h1234_5678; op_b = 32'h9; start = 1'b1;
      for (int i = 1; i <= 20; i++) @(negedge clk);
      reset = 1'b1; start = 1'b0;
      @(negedge clk);
      chk("rst_mid_done", 32'(done), 32'd0);
      chk("rst_mid_result", result, 32'h0);
      chk("rst_mid_stall", 32'(stall), 32'd0);
      reset = 1'b0;
      last_res = 32'h0;
      @(negedge clk);

      // inputs wiggled during CALC must not disturb the latched operation
      do_op("toggle", F3_MULHU, 32'hDEAD_BEEF, 32'h1234_5678,
            ref_md(F3_MULHU, 32'hDEAD_BEEF, 32'h1234_5678), 35, 0, 1);

      // back-to-back: start held through DONE, next op accepted from IDLE
      do_op("b2b_1", F3_DIVU, 32'd1000, 32'd10, 32'd100, 35, 1, 0);
      d1 = last_done_cyc;
      @(negedge clk);
      do_op("b2b_2", F3_MUL, 32'd6, 32'd7, 32'd42, 35, 0, 0);
      chk("b2b_gap", 32'(last_done_cyc - d1), 32'd36);

      // randomized operations against the reference model
      for (int k = 0; k < 40; k++) begin
         f = 3'($urandom_range(7, 0));
         a = pick();
         b = pick();
         do_op("rand", f, a, b, ref_md(f, a, b), ref_lat(f, a, b), 0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
